// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating LSB loads/stores and instruction fetches
// onto a single-port RAM with one-cycle read latency and UART back-pressure on IO stores.
module mem_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        io_buffer_full,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        lsb_todo,
  input  logic [31:0] lsb_addr,
  input  logic [2:0]  lsb_len,
  input  logic        lsb_store,
  input  logic [31:0] lsb_store_data,
  output logic [31:0] lsb_load_res,
  output logic        lsb_done,
  input  logic        if_todo,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        if_done
);

  typedef enum logic [1:0] {StIdle, StIfetch, StLoad, StStore} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [2:0]  len_q, len_d;
  logic [31:0] data_q, data_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] lsb_res_q, lsb_res_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        lsb_done_q, lsb_done_d;
  logic        if_done_q, if_done_d;

  logic [2:0]  norm_len;
  logic [1:0]  cnt_m1;
  logic [31:0] cap;
  logic        io_region;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    buf_d      = buf_q;
    lsb_res_d  = lsb_res_q;
    if_inst_d  = if_inst_q;
    lsb_done_d = lsb_done_q;
    if_done_d  = if_done_q;
    mem_a      = addr_q + {29'd0, cnt_q};
    mem_dout   = 8'd0;
    mem_wr     = 1'b0;

    case (lsb_len)
      3'd1:    norm_len = 3'd1;
      3'd2:    norm_len = 3'd2;
      default: norm_len = 3'd4;
    endcase

    // In read cycle k the byte arriving on mem_din belongs to index k-1.
    cnt_m1    = cnt_q[1:0] - 2'd1;
    cap       = buf_q | ({24'd0, mem_din} << {cnt_m1, 3'b000});
    io_region = (addr_q[17:16] == 2'b11);

    // Done pulses only drop on an enabled edge so they hold through a pause.
    if (rdy_in) begin
      lsb_done_d = 1'b0;
      if_done_d  = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (rdy_in && !lsb_done_q && !if_done_q) begin
          if (lsb_todo) begin
            addr_d  = lsb_addr;
            len_d   = norm_len;
            data_d  = lsb_store_data;
            cnt_d   = 3'd0;
            buf_d   = 32'd0;
            state_d = lsb_store ? StStore : StLoad;
          end else if (if_todo) begin
            addr_d  = if_addr;
            len_d   = 3'd4;
            cnt_d   = 3'd0;
            buf_d   = 32'd0;
            state_d = StIfetch;
          end
        end
      end

      StIfetch, StLoad: begin
        // While paused, keep presenting the byte whose capture is pending so it
        // is on mem_din again when the pause ends.
        if (!rdy_in && cnt_q != 3'd0) begin
          mem_a = addr_q + {29'd0, cnt_q} - 32'd1;
        end
        if (rdy_in) begin
          if (cnt_q != 3'd0) begin
            buf_d = cap;
          end
          if (cnt_q == len_q) begin
            state_d = StIdle;
            if (state_q == StLoad) begin
              lsb_res_d  = cap;
              lsb_done_d = 1'b1;
            end else begin
              if_inst_d = cap;
              if_done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      StStore: begin
        mem_dout = data_q[{cnt_q[1:0], 3'b000} +: 8];
        if (rdy_in && !(io_region && io_buffer_full)) begin
          mem_wr = 1'b1;
          if (cnt_q == len_q - 3'd1) begin
            state_d    = StIdle;
            lsb_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= StIdle;
      addr_q     <= 32'd0;
      len_q      <= 3'd0;
      data_q     <= 32'd0;
      cnt_q      <= 3'd0;
      buf_q      <= 32'd0;
      lsb_res_q  <= 32'd0;
      if_inst_q  <= 32'd0;
      lsb_done_q <= 1'b0;
      if_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      lsb_res_q  <= lsb_res_d;
      if_inst_q  <= if_inst_d;
      lsb_done_q <= lsb_done_d;
      if_done_q  <= if_done_d;
    end
  end

  assign lsb_load_res = lsb_res_q;
  assign lsb_done     = lsb_done_q;
  assign if_inst      = if_inst_q;
  assign if_done      = if_done_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: transaction-level reference model with a shadow RAM, directed
// scenarios pinned by literal values, then randomized requests, pauses and resets.
module tb_mem_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, io_buffer_full;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        lsb_todo, lsb_store, lsb_done;
  logic [31:0] lsb_addr, lsb_store_data, lsb_load_res;
  logic [2:0]  lsb_len;
  logic        if_todo, if_done;
  logic [31:0] if_addr, if_inst;

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .rdy_in         (rdy_in),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .lsb_todo       (lsb_todo),
    .lsb_addr       (lsb_addr),
    .lsb_len        (lsb_len),
    .lsb_store      (lsb_store),
    .lsb_store_data (lsb_store_data),
    .lsb_load_res   (lsb_load_res),
    .lsb_done       (lsb_done),
    .if_todo        (if_todo),
    .if_addr        (if_addr),
    .if_inst        (if_inst),
    .if_done        (if_done)
  );

  // Physical RAM seen by the DUT (4 KiB, aliased) and the model's shadow copy.
  logic [7:0] ram     [4096];
  logic [7:0] exp_ram [4096];

  always @(posedge clk_in) mem_din <= ram[mem_a[11:0]];

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  // Reference model: one transaction = n "advancing" cycles (reads need n+1).
  bit          m_busy, m_store, m_fetch;
  logic [31:0] m_base, m_data;
  int          m_n, m_e;
  bit          m_lsb_done, m_if_done, m_post_rst;
  logic [31:0] m_lsb_res, m_if_inst;
  bit          exp_wr;
  bit          obs_lsb_done, obs_if_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [31:0] ram_word(input logic [31:0] base, input int n);
    logic [31:0] r;
    logic [31:0] a;
    r = 32'd0;
    for (int k = 0; k < n; k++) begin
      a = base + 32'(k);
      r = r | ({24'd0, exp_ram[a[11:0]]} << (8 * k));
    end
    return r;
  endfunction

  task automatic poke(input logic [31:0] a, input logic [7:0] b);
    ram[a[11:0]]     = b;
    exp_ram[a[11:0]] = b;
  endtask

  // Mid-cycle: compare DUT outputs with the model, then let the RAM take any write.
  task automatic half();
    logic [31:0] a;
    @(negedge clk_in);
    exp_wr = m_busy && m_store && rdy_in && !(m_base[17:16] == 2'b11 && io_buffer_full);
    chk("mem_wr", 32'(mem_wr), 32'(exp_wr));
    if (exp_wr) begin
      chk("wr_addr", mem_a, m_base + 32'(m_e));
      chk("wr_data", 32'(mem_dout), 32'(8'(m_data >> (8 * m_e))));
    end
    if (m_busy && !m_store) begin
      if (rdy_in && m_e < m_n) chk("rd_addr", mem_a, m_base + 32'(m_e));
      else if (!rdy_in && m_e >= 1) chk("rd_pause_addr", mem_a, m_base + 32'(m_e) - 32'd1);
    end
    chk("lsb_done", 32'(lsb_done), 32'(m_lsb_done));
    chk("if_done", 32'(if_done), 32'(m_if_done));
    chk("lsb_load_res", lsb_load_res, m_lsb_res);
    chk("if_inst", if_inst, m_if_inst);
    if (m_post_rst) begin
      chk("rst_mem_a", mem_a, 32'd0);
      chk("rst_mem_dout", 32'(mem_dout), 32'd0);
      m_post_rst = 1'b0;
    end
    obs_lsb_done = lsb_done;
    obs_if_done  = if_done;
    if (mem_wr) ram[mem_a[11:0]] = mem_dout;
  endtask

  // Advance the model across the clock edge, then move to just after the edge.
  task automatic adv();
    bit          old_done;
    logic [31:0] a;
    if (exp_wr) begin
      a = m_base + 32'(m_e);
      exp_ram[a[11:0]] = 8'(m_data >> (8 * m_e));
    end
    if (rst_in) begin
      m_busy     = 1'b0;
      m_lsb_done = 1'b0;
      m_if_done  = 1'b0;
      m_lsb_res  = 32'd0;
      m_if_inst  = 32'd0;
      m_post_rst = 1'b1;
    end else if (rdy_in) begin
      old_done   = m_lsb_done || m_if_done;
      m_lsb_done = 1'b0;
      m_if_done  = 1'b0;
      if (m_busy) begin
        if (m_store) begin
          if (exp_wr) begin
            m_e++;
            if (m_e == m_n) begin
              m_busy     = 1'b0;
              m_lsb_done = 1'b1;
            end
          end
        end else if (m_e == m_n) begin
          m_busy = 1'b0;
          if (m_fetch) begin
            m_if_inst = ram_word(m_base, m_n);
            m_if_done = 1'b1;
          end else begin
            m_lsb_res  = ram_word(m_base, m_n);
            m_lsb_done = 1'b1;
          end
        end else begin
          m_e++;
        end
      end else if (!old_done) begin
        if (lsb_todo) begin
          m_busy  = 1'b1;
          m_store = lsb_store;
          m_fetch = 1'b0;
          m_base  = lsb_addr;
          m_data  = lsb_store_data;
          m_n     = (lsb_len == 3'd1) ? 1 : (lsb_len == 3'd2) ? 2 : 4;
          m_e     = 0;
        end else if (if_todo) begin
          m_busy  = 1'b1;
          m_store = 1'b0;
          m_fetch = 1'b1;
          m_base  = if_addr;
          m_n     = 4;
          m_e     = 0;
        end
      end
    end
    cyc++;
    @(posedge clk_in);
    #1;
  endtask

  task automatic tick();
    half();
    adv();
  endtask

  task automatic set_lsb(input logic [31:0] a, input logic [2:0] len, input logic st,
                         input logic [31:0] d);
    lsb_todo       = 1'b1;
    lsb_addr       = a;
    lsb_len        = len;
    lsb_store      = st;
    lsb_store_data = d;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      ram[i]     = 8'($urandom);
      exp_ram[i] = ram[i];
    end
    m_busy = 0; m_store = 0; m_fetch = 0; m_base = 0; m_data = 0; m_n = 0; m_e = 0;
    m_lsb_done = 0; m_if_done = 0; m_post_rst = 0; m_lsb_res = 0; m_if_inst = 0;
    rst_in = 1'b1; rdy_in = 1'b1; io_buffer_full = 1'b0;
    lsb_todo = 1'b0; lsb_addr = 0; lsb_len = 0; lsb_store = 0; lsb_store_data = 0;
    if_todo = 1'b0; if_addr = 0;

    @(posedge clk_in);
    #1;
    adv();
    rst_in = 1'b0;
    tick();

    // LW 0x100 -> 0x44332211, addresses in T+1..T+4, done in T+6.
    poke(32'h100, 8'h11); poke(32'h101, 8'h22); poke(32'h102, 8'h33); poke(32'h103, 8'h44);
    set_lsb(32'h100, 3'd4, 1'b0, 32'd0);
    tick();
    for (int k = 0; k < 4; k++) begin
      half(); chk("lw_addr_lit", mem_a, 32'h100 + 32'(k)); adv();
    end
    half(); chk("lw_early_done", 32'(lsb_done), 32'd0); adv();
    half();
    chk("lw_done_lit", 32'(lsb_done), 32'd1);
    chk("lw_res_lit", lsb_load_res, 32'h44332211);
    adv();
    lsb_todo = 1'b0;

    // SB 0x80 to IO 0x30000 with the UART full for 3 cycles.
    set_lsb(32'h0003_0000, 3'd1, 1'b1, 32'h0000_0080);
    tick();
    io_buffer_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      half(); chk("io_stall_wr", 32'(mem_wr), 32'd0); adv();
    end
    io_buffer_full = 1'b0;
    half();
    chk("io_wr_lit", 32'(mem_wr), 32'd1);
    chk("io_addr_lit", mem_a, 32'h0003_0000);
    chk("io_data_lit", 32'(mem_dout), 32'h80);
    adv();
    half(); chk("io_done_lit", 32'(lsb_done), 32'd1); adv();
    lsb_todo = 1'b0;

    // Simultaneous requests: LB served first, fetch accepted after the turnaround.
    poke(32'h200, 8'h7e);
    poke(32'h300, 8'hd4); poke(32'h301, 8'hc3); poke(32'h302, 8'hb2); poke(32'h303, 8'ha1);
    set_lsb(32'h200, 3'd1, 1'b0, 32'd0);
    if_todo = 1'b1;
    if_addr = 32'h300;
    tick();
    for (int c = 1; c <= 10; c++) begin
      half();
      if (c == 3) begin
        chk("arb_lsb_done", 32'(lsb_done), 32'd1);
        chk("arb_lsb_res", lsb_load_res, 32'h7e);
      end
      if (c == 5) chk("arb_if_addr", mem_a, 32'h300);
      if (c == 9) chk("arb_if_early", 32'(if_done), 32'd0);
      if (c == 10) begin
        chk("arb_if_done", 32'(if_done), 32'd1);
        chk("arb_if_inst", if_inst, 32'ha1b2c3d4);
      end
      adv();
      if (c == 3) lsb_todo = 1'b0;
      if (c == 10) if_todo = 1'b0;
    end

    // LH at the top of the address space wraps to 0.
    poke(32'hffff_ffff, 8'h5a); poke(32'h0, 8'ha5);
    set_lsb(32'hffff_ffff, 3'd2, 1'b0, 32'd0);
    tick();
    for (int c = 1; c <= 4; c++) begin
      half();
      if (c == 1) chk("wrap_addr0", mem_a, 32'hffff_ffff);
      if (c == 2) chk("wrap_addr1", mem_a, 32'h0);
      if (c == 4) begin
        chk("wrap_done", 32'(lsb_done), 32'd1);
        chk("wrap_res", lsb_load_res, 32'h0000_a55a);
      end
      adv();
    end
    lsb_todo = 1'b0;

    // Fetch paused for 2 cycles mid-read: done moves from T+6 to T+8.
    poke(32'h400, 8'h01); poke(32'h401, 8'h02); poke(32'h402, 8'h03); poke(32'h403, 8'h04);
    if_todo = 1'b1;
    if_addr = 32'h400;
    tick();
    for (int c = 1; c <= 8; c++) begin
      rdy_in = !(c == 2 || c == 3);
      half();
      if (c == 7) chk("pause_if_early", 32'(if_done), 32'd0);
      if (c == 8) begin
        chk("pause_if_done", 32'(if_done), 32'd1);
        chk("pause_if_inst", if_inst, 32'h04030201);
      end
      adv();
    end
    if_todo = 1'b0;
    rdy_in  = 1'b1;

    // Reset during byte 2 of a SW aborts it.
    set_lsb(32'h500, 3'd4, 1'b1, 32'hdead_beef);
    tick();
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) rst_in = 1'b1;
      half();
      if (c == 3) begin
        chk("sw_b2_wr", 32'(mem_wr), 32'd1);
        chk("sw_b2_addr", mem_a, 32'h502);
        chk("sw_b2_data", 32'(mem_dout), 32'had);
      end
      adv();
    end
    rst_in    = 1'b0;
    lsb_todo  = 1'b0;
    lsb_store = 1'b0;
    for (int c = 4; c <= 8; c++) begin
      half();
      if (c == 4) begin
        chk("abort_wr", 32'(mem_wr), 32'd0);
        chk("abort_addr", mem_a, 32'd0);
      end
      chk("abort_no_done", 32'(lsb_done), 32'd0);
      adv();
    end

    // Randomized traffic with pauses, UART back-pressure and occasional resets.
    for (int c = 0; c < 5000; c++) begin
      rst_in         = ($urandom_range(0, 249) == 0);
      rdy_in         = ($urandom_range(0, 4) != 0);
      io_buffer_full = ($urandom_range(0, 2) == 0);
      if (obs_lsb_done) lsb_todo = 1'b0;
      if (obs_if_done) if_todo = 1'b0;
      if (!lsb_todo && $urandom_range(0, 2) == 0) begin
        lsb_addr = $urandom;
        if ($urandom_range(0, 3) == 0) lsb_addr[17:16] = 2'b11;
        set_lsb(lsb_addr, 3'($urandom), 1'($urandom), $urandom);
      end
      if (!if_todo && $urandom_range(0, 2) == 0) begin
        if_todo = 1'b1;
        if_addr = $urandom;
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL have one clock and a synchronous, active-high reset: clk_in, rst_in; pause enable rdy_in.
REQ-002 clk_in  in  1  rising-edge clock.
REQ-003 rst_in  in  1  synchronous active-high reset.
REQ-004 rdy_in  in  1  global enable; low = hold all state.
REQ-005 io_buffer_full  in  1  UART TX buffer full.
REQ-006 mem_din  in  8  RAM read byte, valid one cycle after mem_a.
REQ-007 mem_dout  out  8  RAM write byte.
REQ-008 mem_a  out  32  RAM byte address.
REQ-009 mem_wr  out  1  1 = write mem_dout to mem_a this cycle.
REQ-010 lsb_todo  in  1  LSB request, held until lsb_done seen.
REQ-011 lsb_addr  in  32  byte address; lsb_len  in  3  byte count 1/2/4; lsb_store  in  1  1 = store.
REQ-012 lsb_store_data  in  32  store data, low lsb_len bytes used.
REQ-013 lsb_load_res  out  32  load result, zero-extended; lsb_done  out  1  one-cycle completion pulse.
REQ-014 if_todo  in  1  fetch request, held until if_done; if_addr  in  32  fetch address.
REQ-015 if_inst  out  32  fetched word; if_done  out  1  one-cycle completion pulse.

Function
REQ-016 SHALL implement states IDLE, IFETCH, LOAD, STORE; exactly one transaction in flight.
REQ-017 IDLE arbitration: lsb_todo beats if_todo; winner latched (addr, len, data) on the accept edge.
REQ-018 Requests SHALL be ignored in any cycle where lsb_done or if_done is high (one-cycle turnaround).
REQ-019 lsb_len not in {1,2,4} SHALL be treated as 4; IFETCH always 4 bytes.
REQ-020 Read (LOAD/IFETCH), request sampled at end of cycle T, n bytes: mem_a = addr+k, mem_wr = 0 in cycle T+1+k, k = 0..n-1.
REQ-021 Read: byte k captured from mem_din at end of cycle T+2+k; assembled little-endian (byte k -> bits 8k+7:8k).
REQ-022 Read: done pulse and result SHALL appear in cycle T+n+2; unread upper bytes zero; then IDLE.
REQ-023 STORE: byte k driven with mem_a = addr+k, mem_dout = data[8k+7:8k], mem_wr = 1 in cycle T+1+k (no stall).
REQ-024 STORE: lsb_done SHALL pulse in cycle T+n+1; mem_wr = 0 that cycle; then IDLE.
REQ-025 IO region = addr[17:16] == 2'b11; IO store byte SHALL stall (mem_wr = 0, no advance) while io_buffer_full = 1, resuming the cycle after it drops.
REQ-026 IO loads SHALL not stall on io_buffer_full.
REQ-027 Address arithmetic 32-bit, wraps modulo 2^32.
REQ-028 Outside active write cycles mem_wr SHALL be 0; mem_dout don't-care.
REQ-029 rdy_in = 0: state, counters, outputs hold; mem_wr forced 0; read capture skipped, byte reissued on resume.
REQ-030 lsb_load_res / if_inst SHALL hold value until next completion on same port.
REQ-031 lsb_done and if_done SHALL never be high in the same cycle.

Reset
REQ-032 rst_in = 1 at a clock edge: state IDLE, counters 0, mem_a 0, mem_dout 0, mem_wr 0, lsb_done 0, if_done 0, lsb_load_res 0, if_inst 0.
REQ-033 Reset mid-transaction SHALL abort it with no done pulse; further writes are not issued.
REQ-034 Reset SHALL take priority over rdy_in.

Verification
REQ-035 LW at 0x100, RAM 0x100..0x103 = 11 22 33 44 -> mem_a 0x100..0x103 in T+1..T+4; lsb_done at T+6, lsb_load_res 0x44332211.
REQ-036 SB 0x80 to 0x30000 with io_buffer_full high 3 cycles -> mem_wr held 0 for 3 cycles, then one write 0x80; lsb_done one cycle later.
REQ-037 lsb_todo and if_todo asserted same cycle -> LSB served first; fetch starts after turnaround; if_done 6 cycles after accept.
REQ-038 LH at 0xFFFFFFFF -> bytes read from 0xFFFFFFFF and 0x00000000; result upper 16 bits 0.
REQ-039 rdy_in low 2 cycles during a word fetch -> if_done delayed exactly 2 cycles, if_inst correct.
REQ-040 rst_in during SW byte 2 -> mem_wr 0 from next cycle, no lsb_done, state IDLE.
